chip8_sprite_engine: RTL and testbench

- Downstream execution stage of the CHIP-8 instruction fetch/decode unit. It consumes decoded CLS and DRW Vx,Vy,n requests.
- It reads sprite bytes from the 4 KiB main memory at I and XORs them into a 64x32 monochrome framebuffer RAM.
- It reports the VF collision result on completion.
- The framebuffer is 256 bytes: 8 bytes per row, 32 rows. Byte address = y*8 + x[5:3]. Bit 7 of each byte is the leftmost pixel.

---
 rtl/chip8_sprite_engine.sv | 227 ++++++++++++++++++++++
 tb/tb_chip8_sprite_engine.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/chip8_sprite_engine.sv
// chip8_sprite_engine
// Executes decoded CHIP-8 CLS and DRW Vx,Vy,n requests. Sprite bytes are read
// from main memory starting at I and XORed into a 64x32 monochrome framebuffer
// held as 256 bytes (8 bytes per row, bit 7 = leftmost pixel). The VF
// collision result is reported with a one-cycle done pulse.
//
// Ports
//   clk, rst_n                       clock, synchronous active-low reset
//   cmd_valid/cmd_ready              request handshake (ready = idle)
//   cmd_cls, cmd_x, cmd_y, cmd_n     CLS flag, Vx, Vy, sprite height
//   cmd_i                            sprite base address (I register)
//   mem_raddr / mem_d                main memory read port, 1-cycle latency
//   fb_addr / fb_rdata               framebuffer read port, 1-cycle latency
//   fb_wdata / fb_we                 framebuffer write port (shares fb_addr)
//   done / collision                 completion pulse and held VF result
//
// Build option
//   CHIP8_SPRITE_CLIP_EN  clip sprite pixels at the right and bottom edges
//                         instead of wrapping them (start point still wraps).
//
// state | meaning
// IDLE  | ready for a command
// CLS   | writing zero to framebuffer byte fb_addr
// SPR   | sprite address on mem_raddr
// RDL   | left byte address on fb_addr, sprite byte arriving
// RDR   | right byte address on fb_addr, left byte arriving
// WRL   | writing left byte, right byte arriving
// WRR   | writing right byte
// DONE  | raising done and publishing collision
//
// Outputs are registered and loaded on the edge entering the state that uses
// them, so a read address is on the bus one state before its data is captured.
module chip8_sprite_engine #(
    parameter int ADDR_WIDTH    = 12,
    parameter int DATA_WIDTH    = 8,
    parameter int FB_ADDR_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_cls,
    input  logic [7:0]               cmd_x,
    input  logic [7:0]               cmd_y,
    input  logic [3:0]               cmd_n,
    input  logic [ADDR_WIDTH-1:0]    cmd_i,
    output logic [ADDR_WIDTH-1:0]    mem_raddr,
    input  logic [DATA_WIDTH-1:0]    mem_d,
    output logic [FB_ADDR_WIDTH-1:0] fb_addr,
    input  logic [DATA_WIDTH-1:0]    fb_rdata,
    output logic [DATA_WIDTH-1:0]    fb_wdata,
    output logic                     fb_we,
    output logic                     done,
    output logic                     collision
);

    typedef enum logic [2:0] {
        S_IDLE, S_CLS, S_SPR, S_RDL, S_RDR, S_WRL, S_WRR, S_DONE
    } state_t;

    state_t                   r_state;
    logic [5:0]               r_x0;
    logic [4:0]               r_y0;
    logic [3:0]               r_n;
    logic [3:0]               r_row;
    logic [ADDR_WIDTH-1:0]    r_i;
    logic [DATA_WIDTH-1:0]    r_s;
    logic                     r_acc;
    logic                     r_cmd_ready;
    logic [ADDR_WIDTH-1:0]    r_mem_raddr;
    logic [FB_ADDR_WIDTH-1:0] r_fb_addr;
    logic [DATA_WIDTH-1:0]    r_fb_wdata;
    logic                     r_fb_we;
    logic                     r_done;
    logic                     r_collision;

    logic [3:0]               w_row_nx;
    logic [4:0]               w_yrow;
    logic [2:0]               w_col;
    logic [2:0]               w_col_r;
    logic [FB_ADDR_WIDTH-1:0] w_left;
    logic [FB_ADDR_WIDTH-1:0] w_right;
    logic [2*DATA_WIDTH-1:0]  w_spread;
    logic [DATA_WIDTH-1:0]    w_lmask;
    logic [DATA_WIDTH-1:0]    w_rmask;
    logic                     w_do_wrr;
    logic                     w_last;
    logic                     w_unused;

    assign w_row_nx = r_row + 4'd1;
    assign w_yrow   = r_y0 + {1'b0, r_row};
    assign w_col    = r_x0[5:3];
    assign w_col_r  = w_col + 3'd1;
    assign w_left   = FB_ADDR_WIDTH'({w_yrow, w_col});
    assign w_right  = FB_ADDR_WIDTH'({w_yrow, w_col_r});

    // One shift yields both halves: upper byte lands in the left framebuffer
    // byte, the bits pushed out the bottom land in the right byte.
    assign w_spread = {r_s, {DATA_WIDTH{1'b0}}} >> r_x0[2:0];
    assign w_lmask  = w_spread[2*DATA_WIDTH-1:DATA_WIDTH];
    assign w_rmask  = w_spread[DATA_WIDTH-1:0];

`ifdef CHIP8_SPRITE_CLIP_EN
    assign w_do_wrr = (r_x0[2:0] != 3'd0) && (w_col != 3'd7);
    assign w_last   = (w_row_nx == r_n) ||
                      (({1'b0, r_y0} + {2'b00, w_row_nx}) > 6'd31);
`else
    assign w_do_wrr = (r_x0[2:0] != 3'd0);
    assign w_last   = (w_row_nx == r_n);
`endif

    // Vx/Vy upper bits fall away in the mod-64 / mod-32 reduction.
    assign w_unused = &{1'b0, cmd_x[7:6], cmd_y[7:5]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_x0        <= '0;
            r_y0        <= '0;
            r_n         <= '0;
            r_row       <= '0;
            r_i         <= '0;
            r_s         <= '0;
            r_acc       <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_mem_raddr <= '0;
            r_fb_addr   <= '0;
            r_fb_wdata  <= '0;
            r_fb_we     <= 1'b0;
            r_done      <= 1'b0;
            r_collision <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cmd_ready <= 1'b1;
                    if (cmd_valid && r_cmd_ready) begin
                        r_cmd_ready <= 1'b0;
                        r_x0        <= cmd_x[5:0];
                        r_y0        <= cmd_y[4:0];
                        r_n         <= cmd_n;
                        r_i         <= cmd_i;
                        r_row       <= '0;
                        r_acc       <= 1'b0;
                        if (cmd_cls) begin
                            r_state    <= S_CLS;
                            r_fb_we    <= 1'b1;
                            r_fb_addr  <= '0;
                            r_fb_wdata <= '0;
                        end else if (cmd_n == 4'd0) begin
                            r_state <= S_DONE;
                        end else begin
                            r_state     <= S_SPR;
                            r_mem_raddr <= cmd_i;
                        end
                    end
                end
                S_CLS: begin
                    if (r_fb_addr == {FB_ADDR_WIDTH{1'b1}}) begin
                        r_fb_we <= 1'b0;
                        r_state <= S_DONE;
                    end else begin
                        r_fb_addr <= r_fb_addr + FB_ADDR_WIDTH'(1);
                    end
                end
                S_SPR: begin
                    r_fb_addr <= w_left;
                    r_state   <= S_RDL;
                end
                S_RDL: begin
                    r_s       <= mem_d;
                    r_fb_addr <= w_right;
                    r_state   <= S_RDR;
                end
                S_RDR: begin
                    r_fb_we    <= 1'b1;
                    r_fb_addr  <= w_left;
                    r_fb_wdata <= fb_rdata ^ w_lmask;
                    r_acc      <= r_acc | (|(fb_rdata & w_lmask));
                    r_state    <= S_WRL;
                end
                S_WRL: begin
                    if (w_do_wrr) begin
                        r_fb_addr  <= w_right;
                        r_fb_wdata <= fb_rdata ^ w_rmask;
                        r_acc      <= r_acc | (|(fb_rdata & w_rmask));
                        r_state    <= S_WRR;
                    end else begin
                        r_fb_we <= 1'b0;
                        if (w_last) begin
                            r_state <= S_DONE;
                        end else begin
                            r_row       <= w_row_nx;
                            r_mem_raddr <= r_i + ADDR_WIDTH'(w_row_nx);
                            r_state     <= S_SPR;
                        end
                    end
                end
                S_WRR: begin
                    r_fb_we <= 1'b0;
                    if (w_last) begin
                        r_state <= S_DONE;
                    end else begin
                        r_row       <= w_row_nx;
                        r_mem_raddr <= r_i + ADDR_WIDTH'(w_row_nx);
                        r_state     <= S_SPR;
                    end
                end
                S_DONE: begin
                    r_done      <= 1'b1;
                    r_collision <= r_acc;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign mem_raddr = r_mem_raddr;
    assign fb_addr   = r_fb_addr;
    assign fb_wdata  = r_fb_wdata;
    assign fb_we     = r_fb_we;
    assign done      = r_done;
    assign collision = r_collision;

endmodule

// File: tb/tb_chip8_sprite_engine.sv
// Testbench for chip8_sprite_engine: memory and framebuffer RAM models around
// the DUT, a pixel-level reference model of CLS/DRW, directed cases followed
// by randomized commands.
module tb_chip8_sprite_engine;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_cls;
    logic [7:0]  cmd_x;
    logic [7:0]  cmd_y;
    logic [3:0]  cmd_n;
    logic [11:0] cmd_i;
    logic [11:0] mem_raddr;
    logic [7:0]  mem_d;
    logic [7:0]  fb_addr;
    logic [7:0]  fb_rdata;
    logic [7:0]  fb_wdata;
    logic        fb_we;
    logic        done;
    logic        collision;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem    [0:4095];
    logic [7:0] fb     [0:255];
    logic [7:0] ref_fb [0:255];
    logic       tb_fill;
    logic [7:0] tb_fill_val;
    int         we_cnt = 0;

    always #5 clk = ~clk;

    chip8_sprite_engine dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_cls(cmd_cls),
        .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_n(cmd_n), .cmd_i(cmd_i),
        .mem_raddr(mem_raddr), .mem_d(mem_d),
        .fb_addr(fb_addr), .fb_rdata(fb_rdata), .fb_wdata(fb_wdata), .fb_we(fb_we),
        .done(done), .collision(collision)
    );

    always @(posedge clk) mem_d <= mem[mem_raddr];

    always @(posedge clk) begin
        if (tb_fill) begin
            for (int k = 0; k < 256; k++) fb[k] <= tb_fill_val;
        end else if (fb_we) begin
            fb[fb_addr] <= fb_wdata;
        end
        fb_rdata <= fb[fb_addr];
    end

    always @(posedge clk) if (fb_we) we_cnt <= we_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plots each set sprite bit as a pixel on the 64x32 screen.
    task automatic model_cmd(input logic cls, input int x, input int y, input int n,
                             input int i, output int lat, output int wes, output logic coll);
        int x0, y0, rows, px, py, idx;
        logic two;
        logic [7:0] s, m;
        coll = 1'b0;
        if (cls) begin
            for (int k = 0; k < 256; k++) ref_fb[k] = 8'h00;
            lat = 257;
            wes = 256;
            return;
        end
        x0 = x % 64;
        y0 = y % 32;
        rows = n;
        two = (x0 % 8) != 0;
`ifdef CHIP8_SPRITE_CLIP_EN
        if (rows > 32 - y0) rows = 32 - y0;
        if (x0 / 8 == 7) two = 1'b0;
`endif
        lat = rows * (two ? 5 : 4) + 1;
        wes = rows * (two ? 2 : 1);
        for (int r = 0; r < rows; r++) begin
            s = mem[(i + r) % 4096];
            for (int b = 0; b < 8; b++) begin
                if (s[7-b]) begin
                    px = x0 + b;
`ifdef CHIP8_SPRITE_CLIP_EN
                    if (px > 63) continue;
`endif
                    px = px % 64;
                    py = (y0 + r) % 32;
                    idx = py * 8 + px / 8;
                    m = 8'h80 >> (px % 8);
                    if ((ref_fb[idx] & m) != 8'h00) coll = 1'b1;
                    ref_fb[idx] = ref_fb[idx] ^ m;
                end
            end
        end
    endtask

    // Called at a negedge; returns at a negedge one cycle after the done pulse.
    task automatic run_cmd(input logic cls, input int x, input int y, input int n,
                           input int i, input string tag);
        int lat_exp, we_exp, lat, w, we_base, bad;
        logic coll_exp;
        model_cmd(cls, x, y, n, i, lat_exp, we_exp, coll_exp);
        w = 0;
        while (!cmd_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk($sformatf("%s_ready", tag), cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_cls   = cls;
        cmd_x     = 8'(x);
        cmd_y     = 8'(y);
        cmd_n     = 4'(n);
        cmd_i     = 12'(i);
        we_base   = we_cnt;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = 0;
        while (lat < 400) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (done) break;
        end
        chk($sformatf("%s_latency", tag), lat, lat_exp);
        chk($sformatf("%s_done", tag), done, 1);
        chk($sformatf("%s_busy_on_done", tag), cmd_ready, 0);
        chk($sformatf("%s_collision", tag), collision, coll_exp);
        @(negedge clk);
        chk($sformatf("%s_done_width", tag), done, 0);
        chk($sformatf("%s_ready_after", tag), cmd_ready, 1);
        chk($sformatf("%s_coll_held", tag), collision, coll_exp);
        chk($sformatf("%s_fb_we_cycles", tag), we_cnt - we_base, we_exp);
        bad = 0;
        for (int k = 0; k < 256; k++) if (fb[k] !== ref_fb[k]) bad++;
        chk($sformatf("%s_fb_bad_bytes", tag), bad, 0);
    endtask

    initial begin
        int w, sticky;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_cls   = 1'b0;
        cmd_x     = '0;
        cmd_y     = '0;
        cmd_n     = '0;
        cmd_i     = '0;
        tb_fill   = 1'b0;
        tb_fill_val = 8'h00;
        for (int k = 0; k < 4096; k++) mem[k] = 8'($urandom);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_done", done, 0);
        chk("rst_collision", collision, 0);
        chk("rst_fb_we", fb_we, 0);
        chk("rst_fb_addr", fb_addr, 0);
        chk("rst_mem_raddr", mem_raddr, 0);
        chk("rst_fb_wdata", fb_wdata, 0);
        rst_n = 1'b1;

        // Prefill 0xAA then clear.
        tb_fill = 1'b1;
        tb_fill_val = 8'hAA;
        @(posedge clk);
        @(negedge clk);
        tb_fill = 1'b0;
        for (int k = 0; k < 256; k++) ref_fb[k] = 8'hAA;
        run_cmd(1'b1, 0, 0, 0, 0, "cls_prefill");

        mem[12'h300] = 8'hF0;
        run_cmd(1'b0, 0, 0, 1, 12'h300, "drw_aligned");
        chk("drw_aligned_fb0", fb[0], 8'hF0);
        run_cmd(1'b0, 0, 0, 1, 12'h300, "drw_erase");
        chk("drw_erase_fb0", fb[0], 8'h00);
        chk("drw_erase_coll", collision, 1);

        run_cmd(1'b1, 0, 0, 0, 0, "cls2");
        mem[12'h310] = 8'hFF;
        run_cmd(1'b0, 4, 1, 1, 12'h310, "drw_unaligned");
        chk("drw_unaligned_fb8", fb[8], 8'h0F);
        chk("drw_unaligned_fb9", fb[9], 8'hF0);

        run_cmd(1'b1, 0, 0, 0, 0, "cls3");
        mem[12'h320] = 8'hFF;
        mem[12'h321] = 8'hFF;
        run_cmd(1'b0, 62, 31, 2, 12'h320, "drw_corner");
        chk("corner_fb255", fb[255], 8'h03);
`ifdef CHIP8_SPRITE_CLIP_EN
        chk("corner_fb248", fb[248], 8'h00);
        chk("corner_fb7", fb[7], 8'h00);
        chk("corner_fb0", fb[0], 8'h00);
`else
        chk("corner_fb248", fb[248], 8'hFC);
        chk("corner_fb7", fb[7], 8'h03);
        chk("corner_fb0", fb[0], 8'hFC);
`endif

        mem[12'h330] = 8'h80;
        run_cmd(1'b0, 70, 40, 1, 12'h330, "drw_modxy");
        chk("modxy_fb64", fb[64], 8'h02);
        run_cmd(1'b0, 70, 40, 1, 12'h330, "drw_modxy_again");
        chk("modxy_again_coll", collision, 1);

        // Reset on the first write cycle (WRL) of a 15-row draw.
        cmd_valid = 1'b1;
        cmd_cls   = 1'b0;
        cmd_x     = 8'd3;
        cmd_y     = 8'd2;
        cmd_n     = 4'd15;
        cmd_i     = 12'h400;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        w = 0;
        while (!fb_we && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("rst_mid_reached_wrl", fb_we, 1);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_mid_cmd_ready", cmd_ready, 1);
        chk("rst_mid_done", done, 0);
        chk("rst_mid_collision", collision, 0);
        chk("rst_mid_fb_we", fb_we, 0);
        chk("rst_mid_fb_addr", fb_addr, 0);
        chk("rst_mid_mem_raddr", mem_raddr, 0);
        rst_n = 1'b1;
        sticky = 0;
        repeat (80) begin
            @(negedge clk);
            if (done || fb_we) sticky++;
        end
        chk("rst_mid_quiet", sticky, 0);

        run_cmd(1'b1, 0, 0, 0, 0, "cls4");
        run_cmd(1'b0, 5, 5, 0, 12'h123, "drw_n0");

        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 7) == 0)
                run_cmd(1'b1, 0, 0, 0, 0, $sformatf("rnd%0d_cls", t));
            else
                run_cmd(1'b0, $urandom_range(0, 255), $urandom_range(0, 255),
                        $urandom_range(0, 15), $urandom_range(0, 4095),
                        $sformatf("rnd%0d_drw", t));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
